// File: rtl/rv32i_io_ctrl.sv
// Memory-mapped I/O controller: LEDs, synchronised switches, debounced push-buttons and a 4-digit seven-segment scan.
// Optional macro IO_IRQ_EN adds the IRQ_MASK register and a registered push-button edge interrupt.
module rv32i_io_ctrl #(
  parameter int LED_W           = 16,
  parameter int SW_W            = 12,
  parameter int PB_W            = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_DIV        = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [29:0]      io_addr,
  input  logic             io_we,
  input  logic [3:0]       io_be,
  input  logic [31:0]      io_wdata,
  output logic [31:0]      io_rdata,
  input  logic [SW_W-1:0]  sw_in,
  input  logic [PB_W-1:0]  pb_in,
  output logic [LED_W-1:0] leds_out,
  output logic [3:0]       ss_anode,
  output logic [7:0]       ss_cathode,
  output logic             irq
);

  localparam int DB_CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SC_W  = $clog2(SCAN_DIV);
  localparam logic [DB_CW-1:0] DB_LAST   = DB_CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SC_W-1:0]  SCAN_LAST = SC_W'(SCAN_DIV - 1);

  localparam logic [2:0] REG_LED     = 3'd0;
  localparam logic [2:0] REG_SW      = 3'd1;
  localparam logic [2:0] REG_PB      = 3'd2;
  localparam logic [2:0] REG_PB_EDGE = 3'd3;
  localparam logic [2:0] REG_SS_VAL  = 3'd4;
  localparam logic [2:0] REG_SS_CTRL = 3'd5;
  localparam logic [2:0] REG_IRQ_MSK = 3'd6;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Active-low {G,F,E,D,C,B,A} pattern for one hex digit.
  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [6:0] on;
    case (nib)
      4'h0: on = 7'h3F;
      4'h1: on = 7'h06;
      4'h2: on = 7'h5B;
      4'h3: on = 7'h4F;
      4'h4: on = 7'h66;
      4'h5: on = 7'h6D;
      4'h6: on = 7'h7D;
      4'h7: on = 7'h07;
      4'h8: on = 7'h7F;
      4'h9: on = 7'h6F;
      4'hA: on = 7'h77;
      4'hB: on = 7'h7C;
      4'hC: on = 7'h39;
      4'hD: on = 7'h5E;
      4'hE: on = 7'h79;
      4'hF: on = 7'h71;
      default: on = 7'h00;
    endcase
    return ~on;
  endfunction

  logic [SW_W-1:0]  sw_meta_r, sw_sync_r;
  logic [PB_W-1:0]  pb_meta_r, pb_sync_r, pb_db_r, pb_edge_r;
  logic [PB_W-1:0]  pb_toggle_s, pb_rise_s, pb_clr_s;
  logic [DB_CW-1:0] db_cnt_r [PB_W];
  logic [LED_W-1:0] led_r;
  logic [15:0]      ss_val_r;
  logic [7:0]       ss_ctrl_r;
  logic [SC_W-1:0]  scan_cnt_r;
  logic [1:0]       digit_r, digit_nxt_s;
  logic [3:0]       anode_nxt_s;
  logic [7:0]       cathode_nxt_s;
  logic [2:0]       reg_idx_s;
  logic [31:0]      wr_mask_s, rd_s;
  logic [PB_W-1:0]  irq_mask_s;
  logic             wr_led_s, wr_ss_val_s, wr_ss_ctrl_s;
  logic             addr_unused_s;

  assign reg_idx_s     = io_addr[2:0];
  assign wr_mask_s     = lane_mask(io_be);
  assign wr_led_s      = io_we && (reg_idx_s == REG_LED);
  assign wr_ss_val_s   = io_we && (reg_idx_s == REG_SS_VAL);
  assign wr_ss_ctrl_s  = io_we && (reg_idx_s == REG_SS_CTRL);
  assign addr_unused_s = ^{io_addr[29:3], io_wdata, wr_mask_s};
  assign leds_out      = led_r;

  // Debounce toggle and rising-edge detection, plus RW1C clear decode.
  always_comb begin
    pb_clr_s = '0;
    for (int i = 0; i < PB_W; i++) begin
      pb_toggle_s[i] = (pb_sync_r[i] != pb_db_r[i]) && (db_cnt_r[i] == DB_LAST);
    end
    pb_rise_s = pb_toggle_s & ~pb_db_r;
    if (io_we && (reg_idx_s == REG_PB_EDGE)) begin
      pb_clr_s = io_wdata[PB_W-1:0] & wr_mask_s[PB_W-1:0];
    end else begin
      pb_clr_s = '0;
    end
  end

  // Read mux over the current register contents.
  always_comb begin
    rd_s = 32'h0000_0000;
    case (reg_idx_s)
      REG_LED:     rd_s[LED_W-1:0] = led_r;
      REG_SW:      rd_s[SW_W-1:0]  = sw_sync_r;
      REG_PB:      rd_s[PB_W-1:0]  = pb_db_r;
      REG_PB_EDGE: rd_s[PB_W-1:0]  = pb_edge_r;
      REG_SS_VAL:  rd_s[15:0]      = ss_val_r;
      REG_SS_CTRL: rd_s[7:0]       = ss_ctrl_r;
      REG_IRQ_MSK: rd_s[PB_W-1:0]  = irq_mask_s;
      default:     rd_s            = 32'h0000_0000;
    endcase
  end

  // Outputs are decoded from the digit that becomes current on this edge so anode and cathode move together.
  always_comb begin
    if (scan_cnt_r == SCAN_LAST) begin
      digit_nxt_s = digit_r + 2'd1;
    end else begin
      digit_nxt_s = digit_r;
    end
    if (ss_ctrl_r[digit_nxt_s]) begin
      anode_nxt_s   = ~(4'b0001 << digit_nxt_s);
      cathode_nxt_s = {~ss_ctrl_r[{1'b1, digit_nxt_s}], hex_seg(ss_val_r[{digit_nxt_s, 2'b00} +: 4])};
    end else begin
      anode_nxt_s   = 4'hF;
      cathode_nxt_s = 8'hFF;
    end
  end

  // Input synchronisers and per-channel debounce counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sw_meta_r <= '0;
      sw_sync_r <= '0;
      pb_meta_r <= '0;
      pb_sync_r <= '0;
      pb_db_r   <= '0;
      for (int i = 0; i < PB_W; i++) db_cnt_r[i] <= '0;
    end else begin
      sw_meta_r <= sw_in;
      sw_sync_r <= sw_meta_r;
      pb_meta_r <= pb_in;
      pb_sync_r <= pb_meta_r;
      pb_db_r   <= pb_db_r ^ pb_toggle_s;
      for (int i = 0; i < PB_W; i++) begin
        if (pb_sync_r[i] == pb_db_r[i] || pb_toggle_s[i]) begin
          db_cnt_r[i] <= '0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_CW'(1);
        end
      end
    end
  end

  // Software-visible registers and registered read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      led_r     <= '0;
      ss_val_r  <= 16'h0000;
      ss_ctrl_r <= 8'h0F;
      pb_edge_r <= '0;
      io_rdata  <= 32'h0000_0000;
    end else begin
      io_rdata  <= rd_s;
      pb_edge_r <= (pb_edge_r & ~pb_clr_s) | pb_rise_s;
      if (wr_led_s) begin
        led_r <= (led_r & ~wr_mask_s[LED_W-1:0]) | (io_wdata[LED_W-1:0] & wr_mask_s[LED_W-1:0]);
      end
      if (wr_ss_val_s) begin
        ss_val_r <= (ss_val_r & ~wr_mask_s[15:0]) | (io_wdata[15:0] & wr_mask_s[15:0]);
      end
      if (wr_ss_ctrl_s) begin
        ss_ctrl_r <= (ss_ctrl_r & ~wr_mask_s[7:0]) | (io_wdata[7:0] & wr_mask_s[7:0]);
      end
    end
  end

  // Seven-segment scan counter, digit index and display outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_cnt_r <= '0;
      digit_r    <= 2'd0;
      ss_anode   <= 4'hF;
      ss_cathode <= 8'hFF;
    end else begin
      scan_cnt_r <= (scan_cnt_r == SCAN_LAST) ? '0 : scan_cnt_r + SC_W'(1);
      digit_r    <= digit_nxt_s;
      ss_anode   <= anode_nxt_s;
      ss_cathode <= cathode_nxt_s;
    end
  end

`ifdef IO_IRQ_EN
  logic [PB_W-1:0] irq_mask_r;
  assign irq_mask_s = irq_mask_r;

  // Interrupt mask register and registered edge interrupt.
  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_mask_r <= '0;
      irq        <= 1'b0;
    end else begin
      irq <= |(pb_edge_r & irq_mask_r);
      if (io_we && (reg_idx_s == REG_IRQ_MSK)) begin
        irq_mask_r <= (irq_mask_r & ~wr_mask_s[PB_W-1:0]) | (io_wdata[PB_W-1:0] & wr_mask_s[PB_W-1:0]);
      end
    end
  end
`else
  assign irq_mask_s = '0;
  assign irq        = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_io_ctrl.sv
// Randomised bench for rv32i_io_ctrl against a cycle-level behavioural model, plus directed scenarios.
module tb_rv32i_io_ctrl;
  localparam int LED_W = 16;
  localparam int SW_W  = 12;
  localparam int PB_W  = 4;
  localparam int DEB   = 4;
  localparam int SCAN  = 4;

  localparam logic [6:0] SEG_ON [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  localparam logic [3:0] AN_1234 [4] = '{4'hE, 4'hD, 4'hF, 4'h7};
  localparam logic [7:0] CA_1234 [4] = '{8'h19, 8'hB0, 8'hFF, 8'hF9};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [29:0]      io_addr;
  logic             io_we;
  logic [3:0]       io_be;
  logic [31:0]      io_wdata;
  logic [31:0]      io_rdata;
  logic [SW_W-1:0]  sw_in;
  logic [PB_W-1:0]  pb_in;
  logic [LED_W-1:0] leds_out;
  logic [3:0]       ss_anode;
  logic [7:0]       ss_cathode;
  logic             irq;

  rv32i_io_ctrl #(
    .LED_W(LED_W), .SW_W(SW_W), .PB_W(PB_W), .DEBOUNCE_CYCLES(DEB), .SCAN_DIV(SCAN)
  ) dut (
    .clk(clk), .reset(reset), .io_addr(io_addr), .io_we(io_we), .io_be(io_be),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .sw_in(sw_in), .pb_in(pb_in),
    .leds_out(leds_out), .ss_anode(ss_anode), .ss_cathode(ss_cathode), .irq(irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [31:0] m_led, m_ssval, m_ssctrl, m_mask, m_edge, m_lvl, m_rd;
  logic [31:0] m_sw1, m_sw2, m_pb1, m_pb2;
  int          m_run [PB_W];
  int          m_cyc;
  logic [3:0]  m_anode;
  logic [7:0]  m_cath;
  logic        m_irq;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] be);
    logic [31:0] m;
    for (int n = 0; n < 4; n++) m[8*n +: 8] = be[n] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic model_reset();
    m_led = 0; m_ssval = 0; m_ssctrl = 32'h0F; m_mask = 0; m_edge = 0; m_lvl = 0; m_rd = 0;
    m_sw1 = 0; m_sw2 = 0; m_pb1 = 0; m_pb2 = 0; m_cyc = 0;
    m_anode = 4'hF; m_cath = 8'hFF; m_irq = 1'b0;
    for (int i = 0; i < PB_W; i++) m_run[i] = 0;
  endtask

  // Advances the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_edge();
    logic [31:0] wm, clr, rise;
    int idx, d, nib;
    if (!reset) begin
      model_reset();
    end else begin
      idx = int'(io_addr[2:0]);
      case (idx)
        0: m_rd = m_led;
        1: m_rd = m_sw2;
        2: m_rd = m_lvl;
        3: m_rd = m_edge;
        4: m_rd = m_ssval;
        5: m_rd = m_ssctrl;
        6: m_rd = m_mask;
        default: m_rd = 0;
      endcase
`ifdef IO_IRQ_EN
      m_irq = |(m_edge & m_mask);
`else
      m_irq = 1'b0;
`endif
      m_cyc++;
      d = (m_cyc / SCAN) % 4;
      if (m_ssctrl[d]) begin
        nib = int'((m_ssval >> (4 * d)) & 32'hF);
        m_anode = ~(4'b0001 << d);
        m_cath = {~m_ssctrl[4 + d], ~SEG_ON[nib]};
      end else begin
        m_anode = 4'hF;
        m_cath = 8'hFF;
      end
      rise = 0;
      for (int i = 0; i < PB_W; i++) begin
        if (m_pb2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_lvl[i] = ~m_lvl[i];
            m_run[i] = 0;
            rise[i] = m_lvl[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_sw2 = m_sw1; m_sw1 = 32'(sw_in);
      m_pb2 = m_pb1; m_pb1 = 32'(pb_in);
      wm = lanes(io_be);
      clr = 0;
      if (io_we) begin
        case (idx)
          0: m_led = ((m_led & ~wm) | (io_wdata & wm)) & 32'hFFFF;
          3: clr = io_wdata & wm;
          4: m_ssval = ((m_ssval & ~wm) | (io_wdata & wm)) & 32'hFFFF;
          5: m_ssctrl = ((m_ssctrl & ~wm) | (io_wdata & wm)) & 32'hFF;
`ifdef IO_IRQ_EN
          6: m_mask = ((m_mask & ~wm) | (io_wdata & wm)) & 32'hF;
`endif
          default: clr = 0;
        endcase
      end
      m_edge = ((m_edge & ~clr) | rise) & 32'hF;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("rdata", io_rdata, m_rd);
    check_eq("leds", 32'(leds_out), m_led);
    check_eq("anode", 32'(ss_anode), 32'(m_anode));
    check_eq("cathode", 32'(ss_cathode), 32'(m_cath));
    check_eq("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic drive(input logic we, input int idx, input logic [31:0] data, input logic [3:0] be);
    io_we = we;
    io_addr = {27'($urandom), 3'(idx)};
    io_wdata = data;
    io_be = be;
  endtask

  initial begin
    int d, wraps, k;
    logic [3:0] prev_an;
    reset = 1'b0; io_addr = 0; io_we = 1'b0; io_be = 4'h0; io_wdata = 0; sw_in = 0; pb_in = 0;
    model_reset();
    cycle(); cycle();
    check_eq("rst_anode", 32'(ss_anode), 32'h0000_000F);
    check_eq("rst_cathode", 32'(ss_cathode), 32'h0000_00FF);
    check_eq("rst_rdata", io_rdata, 32'h0);
    reset = 1'b1;

    // Byte-lane write then read back
    drive(1'b1, 0, 32'h0000_A5A5, 4'b0001); cycle();
    drive(1'b0, 0, 32'h0, 4'h0); cycle();
    check_eq("led_be", 32'(leds_out), 32'h0000_00A5);
    check_eq("rd_be", io_rdata, 32'h0000_00A5);
    drive(1'b1, 5, 32'h0, 4'h0); cycle();
    drive(1'b0, 5, 32'h0, 4'h0); cycle();
    check_eq("rd_ctrl_rst", io_rdata, 32'h0000_000F);

    // Reset mid-operation discards a pending write
    drive(1'b1, 0, 32'h0000_FFFF, 4'hF); cycle();
    drive(1'b0, 0, 32'h0, 4'h0); cycle();
    check_eq("led_ffff", 32'(leds_out), 32'h0000_FFFF);
    reset = 1'b0;
    drive(1'b1, 0, 32'h0000_1234, 4'hF); cycle();
    check_eq("mid_rst_leds", 32'(leds_out), 32'h0);
    check_eq("mid_rst_anode", 32'(ss_anode), 32'h0000_000F);
    check_eq("mid_rst_cathode", 32'(ss_cathode), 32'h0000_00FF);
    check_eq("mid_rst_rdata", io_rdata, 32'h0);
    reset = 1'b1;
    drive(1'b0, 0, 32'h0, 4'h0); cycle();
    check_eq("mid_rst_nowrite", 32'(leds_out), 32'h0);

    // Debounce: 3-cycle glitch, then a sustained press
    drive(1'b1, 3, 32'hF, 4'hF); cycle();
    drive(1'b0, 2, 32'h0, 4'h0);
    pb_in[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin cycle(); check_eq("pb_glitch", io_rdata, 32'h0); end
    pb_in[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin cycle(); check_eq("pb_glitch", io_rdata, 32'h0); end
    pb_in[1] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      check_eq("pb_hold", io_rdata, (i >= 7) ? 32'h2 : 32'h0);
    end
    drive(1'b0, 3, 32'h0, 4'h0); cycle();
    check_eq("pb_edge", io_rdata, 32'h2);

    // Edge clear racing a new rising edge: set wins
    pb_in[1] = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    drive(1'b1, 3, 32'h2, 4'hF); cycle();
    drive(1'b0, 3, 32'h0, 4'h0); cycle();
    check_eq("edge_clr0", io_rdata, 32'h0);
    pb_in[1] = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    drive(1'b1, 3, 32'h2, 4'hF); cycle();
    drive(1'b0, 3, 32'h0, 4'h0); cycle();
    check_eq("edge_setwins", io_rdata, 32'h2);
    drive(1'b1, 3, 32'h2, 4'hF); cycle();
    drive(1'b0, 3, 32'h0, 4'h0); cycle();
    check_eq("edge_clr", io_rdata, 32'h0);

    // Display scan with digit 2 disabled
    drive(1'b1, 4, 32'h0000_1234, 4'hF); cycle();
    drive(1'b1, 5, 32'h0000_001B, 4'h1); cycle();
    drive(1'b0, 0, 32'h0, 4'h0); cycle(); cycle();
    wraps = 0;
    prev_an = ss_anode;
    for (int i = 0; i < 20; i++) begin
      cycle();
      d = (m_cyc / SCAN) % 4;
      check_eq("ss_anode_dig", 32'(ss_anode), 32'(AN_1234[d]));
      check_eq("ss_cath_dig", 32'(ss_cathode), 32'(CA_1234[d]));
      if (prev_an == 4'h7 && ss_anode == 4'hE) wraps++;
      prev_an = ss_anode;
    end
    check_eq("scan_wrap", 32'(wraps > 0), 32'h1);

`ifdef IO_IRQ_EN
    drive(1'b1, 6, 32'h1, 4'hF); cycle();
    drive(1'b0, 0, 32'h0, 4'h0);
    pb_in[0] = 1'b1;
    k = 0;
    while (k < 30 && !m_edge[0]) begin cycle(); k++; end
    check_eq("irq_wait", 32'(m_edge[0]), 32'h1);
    check_eq("irq_pre", 32'(irq), 32'h0);
    cycle();
    check_eq("irq_set", 32'(irq), 32'h1);
    drive(1'b1, 3, 32'h1, 4'hF); cycle();
    drive(1'b0, 0, 32'h0, 4'h0);
    check_eq("irq_hold", 32'(irq), 32'h1);
    cycle();
    check_eq("irq_clr", 32'(irq), 32'h0);
`else
    drive(1'b1, 6, 32'hF, 4'hF); cycle();
    drive(1'b0, 6, 32'h0, 4'h0); cycle();
    check_eq("mask_ro", io_rdata, 32'h0);
    pb_in[0] = 1'b1;
    k = 0;
    for (int i = 0; i < 20; i++) begin cycle(); k += int'(irq); end
    check_eq("irq_off", 32'(k), 32'h0);
`endif

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 400) != 0;
      drive(($urandom % 3) == 0, int'($urandom % 8), $urandom, 4'($urandom));
      if ($urandom % 4 == 0) sw_in = SW_W'($urandom);
      if ($urandom % 6 == 0) pb_in[$urandom % PB_W] ^= 1'b1;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rv32i_io_ctrl.md
Name: rv32i_io_ctrl

Overview:
Parametrised memory-mapped I/O controller on the MEM-stage io_* interface. It replaces the fixed LED-only I/O module. It drives LEDs, samples and synchronises switches, debounces push-buttons per channel with rising-edge capture, and time-multiplexes a 4-digit seven-segment display. It sits beside dual_port_ram_top and is selected by the MEM stage for the I/O address window.

Parameters:
LED_W, 16, LED register width (1..32)
SW_W, 12, switch input count (1..32)
PB_W, 4, push-button channel count (1..32)
DEBOUNCE_CYCLES, 16, consecutive stable cycles needed before a debounced PB level changes (>=2)
SCAN_DIV, 100000, clock cycles each seven-segment digit stays active (>=2)

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-low reset; sampled on posedge clk, 0 = reset
io_addr  in  30  word address [31:2]; io_addr[4:2] selects the register, upper bits ignored
io_we  in  1  write strobe, one cycle per write
io_be  in  4  byte enables for writes
io_wdata  in  32  write data
io_rdata  out  32  read data, registered
sw_in  in  SW_W  raw asynchronous switches
pb_in  in  PB_W  raw asynchronous buttons, active-high
leds_out  out  LED_W  LED register contents
ss_anode  out  4  digit select, active-low
ss_cathode  out  8  {DP,G,F,E,D,C,B,A}, active-low
irq  out  1  level interrupt (see Optional Feature)

Behaviour:
- Register map (word index io_addr[4:2]):
  - 0 LED: RW, bits [LED_W-1:0].
  - 1 SW: RO, synchronised switches.
  - 2 PB: RO, debounced levels.
  - 3 PB_EDGE: RW1C.
  - 4 SS_VAL: RW, [15:0] four hex nibbles, digit 0 = [3:0].
  - 5 SS_CTRL: RW, [3:0] digit enable, [7:4] DP per digit.
  - 6 IRQ_MASK: RW, [PB_W-1:0].
  - 7: reserved, reads 0, writes ignored.
- Unimplemented bits read 0. Writes apply only to the byte lanes where io_be[n]=1.
- Read latency: io_rdata updates on the posedge after io_addr is presented, independent of io_we. It holds its value otherwise.
- Reset values:
  - LED, SS_VAL, PB_EDGE, IRQ_MASK = 0; SS_CTRL = 0x0F.
  - io_rdata = 0, leds_out = 0, ss_anode = 4'hF, ss_cathode = 8'hFF, irq = 0.
  - Debounced levels = 0, sync flops = 0, scan counter and digit index = 0.
- Synchronisers: two-flop chain on every sw_in and pb_in bit. SW reads the second flop, so there are 2 cycles from a pin change to a readable value.
- Debounce, per channel:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - Synced input == debounced level: counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level toggles on that edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the level.
- Edge capture: a debounced 0->1 transition sets PB_EDGE[i].
  - Software write of 1 to bit i clears it (lane enabled); writing 0 has no effect.
  - Set and clear on the same cycle: set wins.
  - Falling edges are not captured.
- Seven-segment scan:
  - Cycle counter 0..SCAN_DIV-1. On wrap, the digit index advances 0->1->2->3->0.
  - ss_anode[d] = 0 only for the current digit d, and only when SS_CTRL[d]=1.
  - Disabled digit: anode 1 and cathode 8'hFF.
  - Cathodes: registered hex decode of nibble d (0-F, standard segments), DP = ~SS_CTRL[4+d].
  - Anode and cathode switch on the same edge, so there is no ghosting skew.
- Reset mid-operation: all state returns to reset values on the next edge. A pending write on that cycle is discarded.

Optional Feature:
Macro IO_IRQ_EN.
- Defined:
  - irq is registered, irq = |(PB_EDGE & IRQ_MASK).
  - It asserts 1 cycle after the edge bit sets and deasserts 1 cycle after the clear write.
  - IRQ_MASK is RW.
- Undefined:
  - irq is tied 0.
  - IRQ_MASK reads 0 and ignores writes; the mask flops are not synthesised.

Test Plan:
- Register access. Override DEBOUNCE_CYCLES=4, SCAN_DIV=4 for the bench.
  - Stimulus: write 0x0000_A5A5 to index 0 with be=4'b0001, then read index 0.
  - Response: leds_out=0x00A5 and io_rdata=0x0000_00A5 one cycle after the read address.
- Reset:
  - Stimulus: drive reset=0 for 1 cycle after LED=0xFFFF.
  - Response: leds_out=0, ss_anode=4'hF, ss_cathode=8'hFF, io_rdata=0 on the next edge.
- Debounce:
  - Stimulus: pb_in[1] pulses high for 3 cycles, then holds high for 10 cycles.
  - Response: PB[1] stays 0 during the pulse; PB[1]=1 exactly 2+4 cycles into the hold; PB_EDGE=0x2.
- Edge clear:
  - Stimulus: write 0x2 to PB_EDGE on the same cycle as a new pb_in[1] debounced rising edge.
  - Response: PB_EDGE[1] remains 1. A subsequent write of 0x2 alone reads back 0.
- Display:
  - Stimulus: SS_VAL=0x1234, SS_CTRL=0x1B.
  - Response:
    - Digit 0 cathode=8'b0_0011001 ("4"), DP on.
    - Digit 2 anode stays 1, cathode 8'hFF.
    - Digits rotate every 4 cycles and wrap 3->0.
- IRQ, with IO_IRQ_EN:
  - Stimulus: set IRQ_MASK=0x1, press pb0.
  - Response: irq=1 one cycle after PB_EDGE[0] sets; clearing PB_EDGE[0] drops irq the next cycle.
  - Without the macro: irq stays 0 throughout.
